// File: rtl/forward_ctrl_unit.sv
// EX-stage forwarding select and load-use stall controller.
// Shadows ID/EX, EX/MEM and MEM/WB destination state from ID decode.
module forward_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              uses_rs1;
    logic              uses_rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wb_slot_t;

  ex_slot_t  ex_q;
  ex_slot_t  ex_d;
  mem_slot_t mem_q;
  wb_slot_t  wb_q;

  logic ex_load;
  logic hit1;
  logic hit2;
  logic mem_wr;
  logic wb_wr;
  logic a_mem;
  logic a_wb;
  logic b_mem;
  logic b_wb;

  // Load in EX whose rd is read by the instruction in ID
  assign ex_load = ex_q.valid & ex_q.mem_read
                 & (ex_q.rd != '0);
  assign hit1 = id_uses_rs1 & (id_rs1 == ex_q.rd);
  assign hit2 = id_uses_rs2 & (id_rs2 == ex_q.rd);
  assign stall = id_valid & ~flush & ex_load
               & (hit1 | hit2);

  always_comb begin
    ex_d = '0;
    if (id_valid && !flush && !stall) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.uses_rs1  = id_uses_rs1;
      ex_d.uses_rs2  = id_uses_rs2;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q            <= ex_d;
      mem_q.valid     <= ex_q.valid;
      mem_q.rd        <= ex_q.rd;
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.mem_read  <= ex_q.mem_read;
      wb_q.valid      <= mem_q.valid;
      wb_q.rd         <= mem_q.rd;
      wb_q.reg_write  <= mem_q.reg_write;
    end
  end

  assign mem_wr = mem_q.valid & mem_q.reg_write
                & (mem_q.rd != '0);
  assign wb_wr  = wb_q.valid & wb_q.reg_write
                & (wb_q.rd != '0);

  // A load in MEM carries an address, never forward it
  assign a_mem = ex_q.uses_rs1 & mem_wr & ~mem_q.mem_read
               & (mem_q.rd == ex_q.rs1);
  assign a_wb  = ex_q.uses_rs1 & wb_wr & ~a_mem
               & (wb_q.rd == ex_q.rs1);
  assign b_mem = ex_q.uses_rs2 & mem_wr & ~mem_q.mem_read
               & (mem_q.rd == ex_q.rs2);
  assign b_wb  = ex_q.uses_rs2 & wb_wr & ~b_mem
               & (wb_q.rd == ex_q.rs2);

  always_comb begin
    forward_a = 2'b00;
    unique case (1'b1)
      a_mem:   forward_a = 2'b10;
      a_wb:    forward_a = 2'b01;
      default: forward_a = 2'b00;
    endcase
  end

  always_comb begin
    forward_b = 2'b00;
    unique case (1'b1)
      b_mem:   forward_b = 2'b10;
      b_wb:    forward_b = 2'b01;
      default: forward_b = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Scoreboard bench for forward_ctrl_unit: history model of EX occupants,
// expected results queued per cycle and checked by a negedge monitor.
module tb_forward_ctrl_unit;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    bit          v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          u1;
    bit          u2;
    logic [4:0]  rd;
    bit          rw;
    bit          mr;
  } ins_t;

  typedef struct {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0;
  logic [AW-1:0] id_rs2 = '0;
  logic          id_uses_rs1 = 1'b0;
  logic          id_uses_rs2 = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          id_reg_write = 1'b0;
  logic          id_mem_read = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    forward_a;
  logic [1:0]    forward_b;
  logic          stall;
  logic [CW-1:0] stall_count;

  forward_ctrl_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  // Instructions that entered EX, one entry per cycle (bubble = invalid)
  ins_t hist[$];
  int cnt = 0;
  bit last_stall = 0;

  task automatic chk(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("forward_a", int'(forward_a), int'(e.fa));
      chk("forward_b", int'(forward_b), int'(e.fb));
      chk("stall", int'(stall), int'(e.st));
      chk("stall_count", int'(stall_count), int'(e.cnt));
    end
  end

  function automatic ins_t bub();
    ins_t b;
    b = '{v:0, rs1:0, rs2:0, u1:0, u2:0, rd:0, rw:0, mr:0};
    return b;
  endfunction

  function automatic ins_t mk(int rs1, int rs2, bit u1, bit u2,
                              int rd, bit rw, bit mr);
    ins_t i;
    i.v = 1; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.u1 = u1; i.u2 = u2; i.rd = 5'(rd); i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic bit writes(ins_t p, logic [4:0] r);
    return p.v && p.rw && p.rd != 0 && p.rd == r;
  endfunction

  // Newest older producer wins; loads one ahead have no data yet
  function automatic logic [1:0] fwd(bit use_it, logic [4:0] src);
    ins_t m;
    ins_t w;
    m = hist[hist.size()-2];
    w = hist[hist.size()-3];
    if (!use_it) return 2'b00;
    if (writes(m, src) && !m.mr) return 2'b10;
    if (writes(w, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(bub());
    cnt = 0;
    last_stall = 0;
  endtask

  task automatic step(ins_t id, bit fl);
    exp_t e;
    ins_t ex;
    bit st;
    @(posedge clk);
    #1;
    id_valid = id.v; id_rs1 = id.rs1; id_rs2 = id.rs2;
    id_uses_rs1 = id.u1; id_uses_rs2 = id.u2;
    id_rd = id.rd; id_reg_write = id.rw; id_mem_read = id.mr;
    flush = fl;
    ex = hist[hist.size()-1];
    st = id.v && !fl && ex.v && ex.mr && ex.rd != 0 &&
         ((id.u1 && id.rs1 == ex.rd) || (id.u2 && id.rs2 == ex.rd));
    e.fa = fwd(ex.u1, ex.rs1);
    e.fb = fwd(ex.u2, ex.rs2);
    e.st = st;
    e.cnt = CW'(cnt);
    q.push_back(e);
    if (st && cnt < CMAX) cnt++;
    last_stall = st;
    hist.push_back((id.v && !fl && !st) ? id : bub());
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic idle(int n);
    repeat (n) step(bub(), 0);
  endtask

  task automatic reset_mid();
    exp_t z;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_fa", int'(forward_a), 0);
    chk("async_fb", int'(forward_b), 0);
    chk("async_stall", int'(stall), 0);
    chk("async_cnt", int'(stall_count), 0);
    z = '{fa:2'b00, fb:2'b00, st:1'b0, cnt:'0};
    q.push_back(z);
    model_reset();
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    flush = 1'b0;
    q.push_back(z);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t z;
    ins_t r;
    int guard;
    model_reset();
    z = '{fa:2'b00, fb:2'b00, st:1'b0, cnt:'0};
    repeat (2) begin
      @(posedge clk);
      #1;
      q.push_back(z);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Independent reads of x5/x6 after reset
    repeat (4) step(mk(5, 6, 1, 1, 0, 0, 0), 0);
    // add x5 ; sub x?,x5,x5
    step(mk(1, 2, 1, 1, 5, 1, 0), 0);
    step(mk(5, 5, 1, 1, 9, 1, 0), 0);
    idle(3);
    // add x5 ; independent ; use x5
    step(mk(1, 2, 1, 1, 5, 1, 0), 0);
    step(mk(3, 4, 1, 1, 10, 1, 0), 0);
    step(mk(5, 5, 1, 1, 11, 1, 0), 0);
    idle(3);
    // add x5 ; addi x5 ; use x5
    step(mk(1, 2, 1, 1, 5, 1, 0), 0);
    step(mk(5, 0, 1, 0, 5, 1, 0), 0);
    step(mk(5, 6, 1, 1, 12, 1, 0), 0);
    idle(3);
    // Back-to-back producers, consumers 1/2/3 behind
    step(mk(1, 2, 1, 1, 13, 1, 0), 0);
    step(mk(1, 2, 1, 1, 14, 1, 0), 0);
    step(mk(1, 2, 1, 1, 15, 1, 0), 0);
    step(mk(13, 14, 1, 1, 16, 1, 0), 0);
    idle(3);
    // ld x7 ; add rs2=x7 (stall then held retry)
    step(mk(1, 0, 1, 0, 7, 1, 1), 0);
    step(mk(2, 7, 1, 1, 8, 1, 0), 0);
    step(mk(2, 7, 1, 1, 8, 1, 0), 0);
    idle(3);
    // ld x0 ; add rs2=x0: no stall, no forward
    step(mk(1, 0, 1, 0, 0, 1, 1), 0);
    step(mk(2, 0, 1, 1, 8, 1, 0), 0);
    idle(3);
    // ld x7 ; add rs1=x7 squashed by flush
    step(mk(1, 0, 1, 0, 7, 1, 1), 0);
    step(mk(7, 3, 1, 1, 8, 1, 0), 1);
    idle(3);
    // Saturate the counter with load-use pairs
    for (int k = 0; k < 18; k++) begin
      step(mk(1, 0, 1, 0, 7, 1, 1), 0);
      step(mk(7, 2, 1, 1, 8, 1, 0), 0);
      step(mk(7, 2, 1, 1, 8, 1, 0), 0);
    end
    idle(2);
    // Reset with producers in flight
    step(mk(1, 2, 1, 1, 5, 1, 0), 0);
    step(mk(1, 2, 1, 1, 6, 1, 0), 0);
    reset_mid();
    step(mk(5, 6, 1, 1, 9, 1, 0), 0);
    step(mk(5, 6, 1, 1, 9, 1, 0), 0);
    idle(2);

    // Random traffic on a small register window to provoke hazards
    r = bub();
    for (int k = 0; k < 400; k++) begin
      if (!last_stall) begin
        r.v = ($urandom_range(0, 9) != 0);
        r.rs1 = 5'($urandom_range(0, 5));
        r.rs2 = 5'($urandom_range(0, 5));
        r.u1 = 1'($urandom_range(0, 1));
        r.u2 = 1'($urandom_range(0, 1));
        r.rd = 5'($urandom_range(0, 5));
        r.rw = ($urandom_range(0, 3) != 0);
        r.mr = ($urandom_range(0, 2) == 0);
      end
      step(r, $urandom_range(0, 9) == 0);
      if (k == 200) reset_mid();
    end
    idle(2);

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
